// File: rtl/cpu_pkg.sv
// Shared processor-wide constants for the datapath.
package cpu_pkg;

  // Instruction address width used across fetch and next-PC logic.
  localparam int unsigned ADDR_WIDTH = 32;

  // Address the PC returns to on a synchronous clear.
  localparam logic [ADDR_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/pc_register.sv
// Program-counter state register: holds the current fetch address.
// Pure storage; increment and branch selection happen upstream in next-PC logic.
module pc_register
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH       = ADDR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pc_out
);

  logic [WIDTH-1:0] pc_q;

  // Clear has priority over load; otherwise the PC holds its value.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q <= RESET_VALUE;
    end else if (load) begin
      pc_q <= pc_in;
    end
  end

  // Output comes straight from the register, so there is no input-to-output path.
  assign pc_out = pc_q;

endmodule : pc_register

// File: tb/tb_pc_register.sv
// Directed self-checking bench for pc_register.
module tb_pc_register;

  localparam int unsigned W = 32;

  logic         clk;
  logic         clr;
  logic         load;
  logic [W-1:0] pc_in;
  logic [W-1:0] pc_out;

  int unsigned n_asserts;
  int unsigned n_fail;

  pc_register #(
    .WIDTH      (W),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .load  (load),
    .pc_in (pc_in),
    .pc_out(pc_out)
  );

  // 20 ns clock period.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] expected);
    n_asserts++;
    assert (pc_out === expected)
    else begin
      n_fail++;
      $error("FAIL %s: pc_out=%h expected=%h", tag, pc_out, expected);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 ns later.
  task automatic step(input logic c, input logic l, input logic [W-1:0] d,
                      input string tag, input logic [W-1:0] expected);
    clr   = c;
    load  = l;
    pc_in = d;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    clr       = 1'b0;
    load      = 1'b0;
    pc_in     = '0;
    @(negedge clk);

    // Initial clear: pc_out is not checked before this edge.
    step(1'b1, 1'b0, 32'h0000_1234, "reset",           32'h0000_0000);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, "reset_over_load", 32'h0000_0000);

    // Idle hold after clear.
    step(1'b0, 1'b0, 32'h0000_000F, "idle_hold_1", 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0000_000F, "idle_hold_2", 32'h0000_0000);

    // Load and hold.
    step(1'b0, 1'b1, 32'h0000_0007, "load_7",      32'h0000_0007);
    step(1'b0, 1'b0, 32'h0000_0003, "hold_7_1",    32'h0000_0007);
    step(1'b0, 1'b0, 32'h0000_0003, "hold_7_2",    32'h0000_0007);

    // Clear overrides a simultaneous load and persists while clr stays high.
    step(1'b1, 1'b1, 32'h0000_0003, "clr_prio_1",  32'h0000_0000);
    step(1'b1, 1'b1, 32'h0000_0003, "clr_prio_2",  32'h0000_0000);

    // Release clear with load high.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, "release_load", 32'hFFFF_FFFC);

    // Release clear with load low: stays at the reset vector.
    step(1'b1, 1'b0, 32'h0000_0055, "reclear",        32'h0000_0000);
    step(1'b0, 1'b0, 32'hAAAA_AAAA, "release_hold_1", 32'h0000_0000);
    step(1'b0, 1'b0, 32'hAAAA_AAAA, "release_hold_2", 32'h0000_0000);

    // Full-width and odd patterns stored verbatim.
    step(1'b0, 1'b1, 32'hFFFF_FFFF, "load_all_ones", 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 32'h8000_0001, "load_8000_0001", 32'h8000_0001);
    step(1'b0, 1'b1, 32'h1234_5679, "load_unaligned", 32'h1234_5679);

    // Toggle inputs between edges with load low: no effect.
    load  = 1'b0;
    pc_in = 32'h0000_0000;
    #3 pc_in = 32'hFFFF_FFFF;
    #3 pc_in = 32'h5A5A_5A5A;
    #3 check("midcycle_toggle", 32'h1234_5679);
    @(posedge clk);
    #1 check("hold_after_toggle", 32'h1234_5679);

    // Raising load/clr mid-cycle must not reach pc_out before the edge.
    load  = 1'b1;
    pc_in = 32'h0000_0100;
    #4 check("no_comb_load", 32'h1234_5679);
    clr = 1'b1;
    #4 check("no_comb_clr", 32'h1234_5679);
    clr = 1'b0;
    @(posedge clk);
    #1 check("load_after_midcycle", 32'h0000_0100);

    load  = 1'b0;
    pc_in = 32'hCAFE_0000;
    @(posedge clk);
    #1 check("final_hold", 32'h0000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule : tb_pc_register
